// File: rtl/jksrd_using_tff.sv
`default_nettype none
// ============================================================================
//  Module   : jksrd_using_tff
//  Purpose  : JK, SR and D flip-flops each built from a common T flip-flop,
//             cross-checked against behavioural shadow registers, with a
//             saturating SR-illegal (s=r=1) event counter and status FSM.
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  jksrd_tff : plain T flip-flop, q toggles when t is high
// ----------------------------------------------------------------------------
module jksrd_tff (
    input  logic clk,
    input  logic reset,
    input  logic t_i,
    output logic q_o
);

    logic q_q;

    // Toggle storage; asynchronous clear to 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_q ^ t_i;
        end
    end

    assign q_o = q_q;

endmodule

// ----------------------------------------------------------------------------
//  jksrd_using_tff : top level
// ----------------------------------------------------------------------------
module jksrd_using_tff #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             j,
    input  logic             k,
    input  logic             s,
    input  logic             r,
    input  logic             d,
    input  logic             clr_err,
    output logic             q_jk,
    output logic             q_sr,
    output logic             q_d,
    output logic             sr_illegal,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic [1:0]       err_state,
    output logic             mismatch
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_OK   = 2'b00,
        ST_WARN = 2'b01,
        ST_SAT  = 2'b10
    } err_state_t;

    // ------------------------------------------------------------------
    //  Built flip-flops: excitation logic feeding three T flip-flops
    // ------------------------------------------------------------------
    logic w_q_jk;
    logic w_q_sr;
    logic w_q_d;
    logic w_t_jk;
    logic w_t_sr;
    logic w_t_d;
    logic w_sr_both;

    assign w_sr_both = s & r;

    // JK: toggle when the requested level differs from the current one
    assign w_t_jk = (j & ~w_q_jk) | (k & w_q_jk);

    // SR: same idea as JK, but s=r=1 is suppressed so the flop holds
    assign w_t_sr = ((s & ~w_q_sr) | (r & w_q_sr)) & ~w_sr_both;

    // D: toggle whenever d disagrees with the stored value
    assign w_t_d  = d ^ w_q_d;

    jksrd_tff u_tff_jk (
        .clk   (clk),
        .reset (reset),
        .t_i   (w_t_jk),
        .q_o   (w_q_jk)
    );

    jksrd_tff u_tff_sr (
        .clk   (clk),
        .reset (reset),
        .t_i   (w_t_sr),
        .q_o   (w_q_sr)
    );

    jksrd_tff u_tff_d (
        .clk   (clk),
        .reset (reset),
        .t_i   (w_t_d),
        .q_o   (w_q_d)
    );

    assign q_jk = w_q_jk;
    assign q_sr = w_q_sr;
    assign q_d  = w_q_d;

    // ------------------------------------------------------------------
    //  Behavioural shadows written directly from the truth tables
    // ------------------------------------------------------------------
    logic shd_jk_q, shd_jk_d;
    logic shd_sr_q, shd_sr_d;
    logic shd_d_q,  shd_d_d;

    // Shadow next-state from the characteristic tables, not the T logic
    always_comb begin
        shd_jk_d = shd_jk_q;
        shd_sr_d = shd_sr_q;
        shd_d_d  = d;

        case ({j, k})
            2'b01:   shd_jk_d = 1'b0;
            2'b10:   shd_jk_d = 1'b1;
            2'b11:   shd_jk_d = ~shd_jk_q;
            default: shd_jk_d = shd_jk_q;
        endcase

        case ({s, r})
            2'b01:   shd_sr_d = 1'b0;
            2'b10:   shd_sr_d = 1'b1;
            default: shd_sr_d = shd_sr_q;
        endcase
    end

    // Shadow registers advance in lockstep with the built flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shd_jk_q <= 1'b0;
            shd_sr_q <= 1'b0;
            shd_d_q  <= 1'b0;
        end else begin
            shd_jk_q <= shd_jk_d;
            shd_sr_q <= shd_sr_d;
            shd_d_q  <= shd_d_d;
        end
    end

    // ------------------------------------------------------------------
    //  Error bookkeeping: sticky flags and saturating event counter
    // ------------------------------------------------------------------
    logic             sr_illegal_q, sr_illegal_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             mismatch_q,   mismatch_d;
    logic             w_pair_diff;
    logic [CNT_W-1:0] w_cnt_base;

    assign w_pair_diff = (w_q_jk ^ shd_jk_q) | (w_q_sr ^ shd_sr_q) | (w_q_d ^ shd_d_q);

    // A clear takes effect first; a same-edge illegal event then counts
    assign w_cnt_base = clr_err ? '0 : cnt_q;

    // Next values of the sticky flags and counter
    always_comb begin
        sr_illegal_d = clr_err ? 1'b0 : sr_illegal_q;
        mismatch_d   = clr_err ? 1'b0 : mismatch_q;
        cnt_d        = w_cnt_base;

        if (w_sr_both) begin
            sr_illegal_d = 1'b1;
            if (w_cnt_base != C_CNT_MAX) begin
                cnt_d = w_cnt_base + 1'b1;
            end
        end

        if (w_pair_diff) begin
            mismatch_d = 1'b1;
        end
    end

    // Status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_illegal_q <= 1'b0;
            cnt_q        <= '0;
            mismatch_q   <= 1'b0;
        end else begin
            sr_illegal_q <= sr_illegal_d;
            cnt_q        <= cnt_d;
            mismatch_q   <= mismatch_d;
        end
    end

    // ------------------------------------------------------------------
    //  Status FSM: OK -> WARN -> SAT, clr_err returns to OK
    // ------------------------------------------------------------------
    err_state_t state_q, state_d;
    err_state_t w_state_base;

    // Clearing behaves like starting from OK within the same edge
    assign w_state_base = clr_err ? ST_OK : state_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_OK;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, driven by the counter's next value
    always_comb begin
        state_d = w_state_base;
        case (w_state_base)
            ST_OK: begin
                if (w_sr_both) begin
                    state_d = (cnt_d == C_CNT_MAX) ? ST_SAT : ST_WARN;
                end
            end
            ST_WARN: begin
                if (cnt_d == C_CNT_MAX) begin
                    state_d = ST_SAT;
                end
            end
            ST_SAT: begin
                state_d = ST_SAT;
            end
            default: begin
                state_d = ST_OK;
            end
        endcase
    end

    assign sr_illegal  = sr_illegal_q;
    assign illegal_cnt = cnt_q;
    assign err_state   = state_q;
    assign mismatch    = mismatch_q;

endmodule
`default_nettype wire

// File: tb/tb_jksrd_using_tff.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jksrd_using_tff
//  Purpose  : scoreboard bench for jksrd_using_tff against a truth-table model
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jksrd_using_tff;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             j, k, s, r, d, clr_err;
    logic             q_jk, q_sr, q_d, sr_illegal, mismatch;
    logic [CNT_W-1:0] illegal_cnt;
    logic [1:0]       err_state;

    jksrd_using_tff #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .j           (j),
        .k           (k),
        .s           (s),
        .r           (r),
        .d           (d),
        .clr_err     (clr_err),
        .q_jk        (q_jk),
        .q_sr        (q_sr),
        .q_d         (q_d),
        .sr_illegal  (sr_illegal),
        .illegal_cnt (illegal_cnt),
        .err_state   (err_state),
        .mismatch    (mismatch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       qjk;
        logic       qsr;
        logic       qd;
        logic       sri;
        int         cnt;
        logic [1:0] err;
        logic       mm;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic m_jk, m_sr, m_d;
    int   m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_jk  = 1'b0;
        m_sr  = 1'b0;
        m_d   = 1'b0;
        m_cnt = 0;
    endtask

    // Apply one set of inputs on a negedge and queue the post-edge expectation
    task automatic step(input logic ij, input logic ik, input logic is,
                        input logic ir, input logic id, input logic iclr);
        exp_t e;
        @(negedge clk);
        j = ij; k = ik; s = is; r = ir; d = id; clr_err = iclr;

        case ({ij, ik})
            2'b10:   m_jk = 1'b1;
            2'b01:   m_jk = 1'b0;
            2'b11:   m_jk = ~m_jk;
            default: m_jk = m_jk;
        endcase
        if (is && !ir)      m_sr = 1'b1;
        else if (ir && !is) m_sr = 1'b0;
        m_d = id;
        if (iclr) m_cnt = 0;
        if (is && ir) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;

        e.qjk = m_jk;
        e.qsr = m_sr;
        e.qd  = m_d;
        e.sri = (m_cnt != 0);
        e.cnt = m_cnt;
        e.err = (m_cnt == 0) ? 2'b00 : ((m_cnt == CNT_MAX) ? 2'b10 : 2'b01);
        e.mm  = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".q_jk"},        32'(q_jk),        32'd0);
        check({tag, ".q_sr"},        32'(q_sr),        32'd0);
        check({tag, ".q_d"},         32'(q_d),         32'd0);
        check({tag, ".sr_illegal"},  32'(sr_illegal),  32'd0);
        check({tag, ".illegal_cnt"}, 32'(illegal_cnt), 32'd0);
        check({tag, ".err_state"},   32'(err_state),   32'd0);
        check({tag, ".mismatch"},    32'(mismatch),    32'd0);
    endtask

    // Monitor: every rising edge presents a new output set to compare
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("q_jk",        32'(q_jk),        32'(e.qjk));
                check("q_sr",        32'(q_sr),        32'(e.qsr));
                check("q_d",         32'(q_d),         32'(e.qd));
                check("sr_illegal",  32'(sr_illegal),  32'(e.sri));
                check("illegal_cnt", 32'(illegal_cnt), 32'(e.cnt));
                check("err_state",   32'(err_state),   32'(e.err));
                check("mismatch",    32'(mismatch),    32'(e.mm));
            end
        end
    end

    initial begin : stimulus
        int waited;
        reset = 1'b1;
        j = 0; k = 0; s = 0; r = 0; d = 0; clr_err = 0;
        model_reset();

        // Inputs wiggling under reset must be ignored
        @(negedge clk);
        j = 1; s = 1; r = 1; d = 1;
        #7;
        check_all_zero("reset");
        j = 0; s = 0; r = 0; d = 0;
        @(negedge clk);
        reset = 1'b0;

        // JK sequence
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);

        // D follows input one edge later
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);

        // SR set then illegal hold
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Saturation, then clear coinciding with an illegal event
        for (int i = 0; i < 300; i++) step(0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 1, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Build up nonzero state, then pulse reset between edges
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0, 0);
        step(1, 0, 1, 0, 1, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        j = 0; k = 0; s = 0; r = 0; d = 0; clr_err = 0;
        model_reset();
        #1;
        reset = 1'b0;

        // Random traffic
        for (int i = 0; i < 1000; i++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end

        // Let the monitor drain the scoreboard within a bounded time
        waited = 0;
        while (sb_q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d entries left expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
